// File: rtl/ram_sp_clr_if.sv
// Request/response bus for ram_sp_clr: the requester drives the access, and the RAM
// answers with ready, read data and status pulses.
interface ram_sp_clr_if #(
   parameter int DW = 4,
   parameter int AW = 3
);
   logic          req;
   logic          rw;
   logic [AW-1:0] addr;
   logic [DW-1:0] data_in;
   logic          clr;
   logic          ready;
   logic [DW-1:0] data_out;
   logic          rd_valid;
   logic          err;

   modport master (
      output req, rw, addr, data_in, clr,
      input  ready, data_out, rd_valid, err
   );

   modport slave (
      input  req, rw, addr, data_in, clr,
      output ready, data_out, rd_valid, err
   );
endinterface

// File: rtl/ram_sp_clr.sv
// Single-port synchronous RAM with req/ready handshake, registered read port and
// a clear sequencer that sweeps every word to CLR_VAL after reset or on command.
module ram_sp_clr #(
   parameter int              DW      = 4,
   parameter int              AW      = 3,
   parameter int              DEPTH   = 8,
   parameter logic [DW-1:0]   CLR_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   ram_sp_clr_if.slave  bus
);

   typedef enum logic {CLEAR, IDLE} state_t;

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [AW:0]   ADDR_LIM  = (AW + 1)'(DEPTH);

   state_t          state, state_nxt;
   logic [AW-1:0]   cnt, cnt_nxt;
   logic [DW-1:0]   mem [DEPTH];

   logic            accept;
   logic            in_range;
   logic [DW-1:0]   data_out_p1;
   logic            vld_p1;
   logic            err_p1;

   assign in_range = ({1'b0, bus.addr} < ADDR_LIM);
   // clr wins over a concurrent req, so the req is left pending for the requester
   assign accept   = (state == IDLE) && !bus.clr && bus.req;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         CLEAR: begin
            if (cnt == LAST_ADDR) begin
               cnt_nxt   = '0;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + AW'(1);
            end
         end
         IDLE: begin
            if (bus.clr) begin
               cnt_nxt   = '0;
               state_nxt = CLEAR;
            end
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = CLEAR;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Storage array: contents are initialised only by the sweep, never by reset
   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         mem[cnt] <= CLR_VAL;
      end else if (accept && !bus.rw && in_range) begin
         mem[bus.addr] <= bus.data_in;
      end
   end

   // Stage p1: registered read data and one-cycle status pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out_p1 <= '0;
         vld_p1      <= 1'b0;
         err_p1      <= 1'b0;
      end else begin
         vld_p1 <= accept && bus.rw;
         err_p1 <= accept && !in_range;
         if (accept && bus.rw) begin
            data_out_p1 <= in_range ? mem[bus.addr] : '0;
         end
      end
   end

   assign bus.ready    = (state == IDLE);
   assign bus.data_out = data_out_p1;
   assign bus.rd_valid = vld_p1;
   assign bus.err      = err_p1;

endmodule

// File: tb/tb_ram_sp_clr.sv
// Directed bench for ram_sp_clr: a DEPTH=8 instance for the main function and a
// DEPTH=6 instance for out-of-range accesses.
module tb_ram_sp_clr;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   ram_sp_clr_if #(.DW(4), .AW(3)) bus_a ();
   ram_sp_clr_if #(.DW(4), .AW(3)) bus_b ();

   ram_sp_clr #(.DW(4), .AW(3), .DEPTH(8), .CLR_VAL(4'h0)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a.slave)
   );

   ram_sp_clr #(.DW(4), .AW(3), .DEPTH(6), .CLR_VAL(4'h0)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       req;
      logic       rw;
      logic [2:0] addr;
      logic [3:0] din;
      logic       e_ready;
      logic       e_vld;
      logic       e_err;
      logic [3:0] e_dout;
   } vec_t;

   vec_t vt[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic req, input logic rw, input logic [2:0] addr,
                      input logic [3:0] din, input logic e_ready, input logic e_vld,
                      input logic e_err, input logic [3:0] e_dout);
      vec_t v;
      v.req = req; v.rw = rw; v.addr = addr; v.din = din;
      v.e_ready = e_ready; v.e_vld = e_vld; v.e_err = e_err; v.e_dout = e_dout;
      vt.push_back(v);
   endtask

   // Counts samples with ready low, one edge per sample, bounded at 100
   task automatic wait_ready_a(output int n);
      n = 0;
      while (bus_a.ready !== 1'b1 && n < 100) begin
         n++;
         tick();
      end
   endtask

   task automatic wait_ready_b(output int n);
      n = 0;
      while (bus_b.ready !== 1'b1 && n < 100) begin
         n++;
         tick();
      end
   endtask

   task automatic acc_a(input logic rw, input logic [2:0] addr, input logic [3:0] din);
      bus_a.req = 1'b1; bus_a.rw = rw; bus_a.addr = addr; bus_a.data_in = din;
      tick();
      bus_a.req = 1'b0;
   endtask

   task automatic acc_b(input logic rw, input logic [2:0] addr, input logic [3:0] din);
      bus_b.req = 1'b1; bus_b.rw = rw; bus_b.addr = addr; bus_b.data_in = din;
      tick();
      bus_b.req = 1'b0;
   endtask

   initial begin
      int n;
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      bus_a.req = 1'b0; bus_a.rw = 1'b0; bus_a.addr = '0; bus_a.data_in = '0; bus_a.clr = 1'b0;
      bus_b.req = 1'b0; bus_b.rw = 1'b0; bus_b.addr = '0; bus_b.data_in = '0; bus_b.clr = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_ready", bus_a.ready, 1'b0);
      chk("rst_dout", bus_a.data_out, 4'h0);
      chk("rst_vld", bus_a.rd_valid, 1'b0);
      chk("rst_err", bus_a.err, 1'b0);
      rst_n = 1'b1;
      wait_ready_a(n);
      chk("init_sweep_len", n, 8);

      // Table: reads of cleared memory, writes 0..3, reads back-to-back
      for (int i = 0; i < 8; i++) add(1, 1, 3'(i), 4'h0, 1, 1, 0, 4'h0);
      for (int i = 0; i < 4; i++) add(1, 0, 3'(i), 4'(i), 1, 0, 0, 4'h0);
      for (int i = 0; i < 4; i++) add(1, 1, 3'(i), 4'h0, 1, 1, 0, 4'(i));
      add(0, 1, 3'd0, 4'h0, 1, 0, 0, 4'h3);
      add(1, 0, 3'd6, 4'h9, 1, 0, 0, 4'h3);
      add(1, 1, 3'd6, 4'h0, 1, 1, 0, 4'h9);
      add(1, 1, 3'd7, 4'h0, 1, 1, 0, 4'h0);
      for (int i = 0; i < vt.size(); i++) begin
         bus_a.req = vt[i].req; bus_a.rw = vt[i].rw;
         bus_a.addr = vt[i].addr; bus_a.data_in = vt[i].din;
         tick();
         chk($sformatf("vec%0d_ready", i), bus_a.ready, vt[i].e_ready);
         chk($sformatf("vec%0d_vld", i), bus_a.rd_valid, vt[i].e_vld);
         chk($sformatf("vec%0d_err", i), bus_a.err, vt[i].e_err);
         chk($sformatf("vec%0d_dout", i), bus_a.data_out, vt[i].e_dout);
      end
      bus_a.req = 1'b0;

      // Reset during cycle 4 of a sweep; memory pre-filled with nonzero data
      for (int i = 0; i < 8; i++) acc_a(1'b0, 3'(i), 4'(i + 1));
      acc_a(1'b1, 3'd7, 4'h0);
      chk("pre_rst_dout", bus_a.data_out, 4'h8);
      bus_a.clr = 1'b1;
      tick();
      bus_a.clr = 1'b0;
      tick(); tick(); tick();
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_ready", bus_a.ready, 1'b0);
      chk("midrst_dout", bus_a.data_out, 4'h0);
      chk("midrst_vld", bus_a.rd_valid, 1'b0);
      #2 rst_n = 1'b1;
      wait_ready_a(n);
      chk("restart_sweep_len", n, 8);
      for (int i = 0; i < 8; i++) begin
         acc_a(1'b1, 3'(i), 4'h0);
         chk($sformatf("post_rst_rd%0d", i), bus_a.data_out, 4'h0);
         chk($sformatf("post_rst_vld%0d", i), bus_a.rd_valid, 1'b1);
      end

      // clr with concurrent req: req not accepted, addr 5 cleared
      acc_a(1'b0, 3'd5, 4'hA);
      acc_a(1'b1, 3'd5, 4'h0);
      chk("wr5_rd", bus_a.data_out, 4'hA);
      bus_a.clr = 1'b1; bus_a.req = 1'b1; bus_a.rw = 1'b1; bus_a.addr = 3'd5;
      tick();
      bus_a.clr = 1'b0; bus_a.req = 1'b0;
      chk("clr_req_vld", bus_a.rd_valid, 1'b0);
      chk("clr_req_dout", bus_a.data_out, 4'hA);
      wait_ready_a(n);
      chk("clr_sweep_len", n, 8);
      acc_a(1'b1, 3'd5, 4'h0);
      chk("clr_rd5", bus_a.data_out, 4'h0);

      // clr held during CLEAR is ignored
      bus_a.clr = 1'b1;
      tick();
      wait_ready_a(n);
      bus_a.clr = 1'b0;
      chk("clr_held_sweep_len", n, 8);

      // DEPTH=6 instance: out-of-range accesses
      acc_b(1'b0, 3'd5, 4'h9);
      acc_b(1'b1, 3'd5, 4'h0);
      chk("b_rd5", bus_b.data_out, 4'h9);
      chk("b_rd5_err", bus_b.err, 1'b0);
      acc_b(1'b0, 3'd7, 4'hF);
      chk("b_wr7_err", bus_b.err, 1'b1);
      chk("b_wr7_vld", bus_b.rd_valid, 1'b0);
      tick();
      chk("b_err_pulse", bus_b.err, 1'b0);
      acc_b(1'b1, 3'd7, 4'h0);
      chk("b_rd7_err", bus_b.err, 1'b1);
      chk("b_rd7_vld", bus_b.rd_valid, 1'b1);
      chk("b_rd7_dout", bus_b.data_out, 4'h0);
      acc_b(1'b1, 3'd6, 4'h0);
      chk("b_rd6_err", bus_b.err, 1'b1);
      for (int i = 0; i < 6; i++) begin
         acc_b(1'b1, 3'(i), 4'h0);
         chk($sformatf("b_rd%0d", i), bus_b.data_out, (i == 5) ? 4'h9 : 4'h0);
         chk($sformatf("b_rd%0d_err", i), bus_b.err, 1'b0);
      end
      bus_b.clr = 1'b1;
      tick();
      bus_b.clr = 1'b0;
      wait_ready_b(n);
      chk("b_sweep_len", n, 6);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
